// File: rtl/intra4x4_seq_pkg.sv
// Shared definitions for the Intra4x4 prediction-mode sequencer.
//  - seq_state_e : sequencer FSM states
//  - MB_PRED_IDLE / PREV_* / REM_* : mb_pred_state codes seen by the decoder
//  - NUM_BLK : luma 4x4 blocks per macroblock
package intra4x4_seq_pkg;

    localparam int NUM_BLK = 16;

    // Decoder state codes; the prev/rem values mirror the decoder's define.v.
    localparam logic [2:0] MB_PRED_IDLE                   = 3'd0;
    localparam logic [2:0] PREV_INTRA4X4_PRED_MODE_FLAG_S = 3'd1;
    localparam logic [2:0] REM_INTRA4X4_PRED_MODE_S       = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WFLAG = 3'd1,
        S_PREV  = 3'd2,
        S_WREM  = 3'd3,
        S_REM   = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

endpackage

// File: rtl/mb_position_counter.sv
// Raster macroblock position tracker.
// Ports:
//  i_clk, i_reset      clock, synchronous active-high reset
//  i_pic_start         return to (0,0); wins over i_advance
//  i_advance           step to the next MB in raster order
//  i_width_m1/height_m1 picture size in MBs minus 1
//  o_h, o_v            current MB column / row
//  o_pic_done          1-cycle pulse when stepping past the last MB
module mb_position_counter #(
    parameter int MBW = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_pic_start,
    input  logic           i_advance,
    input  logic [MBW-1:0] i_width_m1,
    input  logic [MBW-1:0] i_height_m1,
    output logic [MBW-1:0] o_h,
    output logic [MBW-1:0] o_v,
    output logic           o_pic_done
);

    logic [MBW-1:0] r_h;
    logic [MBW-1:0] r_v;
    logic           r_pic_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_h        <= '0;
            r_v        <= '0;
            r_pic_done <= 1'b0;
        end else begin
            r_pic_done <= 1'b0;
            if (i_pic_start) begin
                r_h <= '0;
                r_v <= '0;
            end else if (i_advance) begin
                if (r_h == i_width_m1) begin
                    r_h <= '0;
                    if (r_v == i_height_m1) begin
                        r_v        <= '0;
                        r_pic_done <= 1'b1;
                    end else begin
                        r_v <= r_v + MBW'(1);
                    end
                end else begin
                    r_h <= r_h + MBW'(1);
                end
            end
        end
    end

    assign o_h        = r_h;
    assign o_v        = r_v;
    assign o_pic_done = r_pic_done;

endmodule

// File: rtl/intra4x4_predmode_seq.sv
// Intra4x4 prediction-mode sequencer. For each I_NxN macroblock it pulls 16
// (prev_intra4x4_pred_mode_flag, rem_intra4x4_pred_mode) pairs from the parser
// and presents them to the decoder one block at a time, while tracking the
// raster MB position.
// Ports:
//  i_clk, i_reset                 clock, synchronous active-high reset
//  i_pic_start/i_mb_start/i_mb_advance  control pulses
//  i_pic_width_in_mbs_minus1, i_pic_height_in_map_units_minus1  picture size
//  i_se_valid/o_se_ready, i_se_flag, i_se_rem  parser handshake and data
//  o_mb_pred_state, o_luma4x4BlkIdx, o_prev_intra4x4_pred_mode_flag,
//  o_rem_intra4x4_pred_mode        decoder interface
//  o_mb_num_h/o_mb_num_v          MB position
//  o_busy, o_mb_done, o_pic_done, o_proto_err  status
module intra4x4_predmode_seq
    import intra4x4_seq_pkg::*;
#(
    parameter int MBW = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_pic_start,
    input  logic           i_mb_start,
    input  logic           i_mb_advance,
    input  logic [MBW-1:0] i_pic_width_in_mbs_minus1,
    input  logic [MBW-1:0] i_pic_height_in_map_units_minus1,
    input  logic           i_se_valid,
    output logic           o_se_ready,
    input  logic           i_se_flag,
    input  logic [2:0]     i_se_rem,
    output logic [2:0]     o_mb_pred_state,
    output logic [3:0]     o_luma4x4BlkIdx,
    output logic           o_prev_intra4x4_pred_mode_flag,
    output logic [2:0]     o_rem_intra4x4_pred_mode,
    output logic [MBW-1:0] o_mb_num_h,
    output logic [MBW-1:0] o_mb_num_v,
    output logic           o_busy,
    output logic           o_mb_done,
    output logic           o_pic_done,
    output logic           o_proto_err
);

    localparam logic [3:0] LAST_BLK = 4'(NUM_BLK - 1);

    seq_state_e r_state;
    seq_state_e w_next;
    logic [3:0] r_blk;
    logic       r_flag;
    logic [2:0] r_rem;
    logic       r_proto_err;
    logic       w_xfer;
    logic       w_idle;
    logic       w_blk_step;

    assign w_idle = (r_state == S_IDLE);
    assign w_xfer = i_se_valid & o_se_ready;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_mb_start) w_next = S_WFLAG;
            S_WFLAG: if (w_xfer)     w_next = S_PREV;
            S_PREV: begin
                if (!r_flag)                w_next = S_WREM;
                else if (r_blk == LAST_BLK) w_next = S_DONE;
                else                        w_next = S_WFLAG;
            end
            S_WREM:  if (w_xfer)     w_next = S_REM;
            S_REM:   w_next = (r_blk == LAST_BLK) ? S_DONE : S_WFLAG;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        o_se_ready      = 1'b0;
        o_busy          = 1'b0;
        o_mb_done       = 1'b0;
        o_mb_pred_state = MB_PRED_IDLE;
        case (r_state)
            S_WFLAG: begin o_se_ready = 1'b1; o_busy = 1'b1; end
            S_PREV:  begin o_busy = 1'b1; o_mb_pred_state = PREV_INTRA4X4_PRED_MODE_FLAG_S; end
            S_WREM:  begin o_se_ready = 1'b1; o_busy = 1'b1; end
            S_REM:   begin o_busy = 1'b1; o_mb_pred_state = REM_INTRA4X4_PRED_MODE_S; end
            S_DONE:  o_mb_done = 1'b1;
            default: ;
        endcase
    end

    // A block ends after PREV with flag=1 or after REM; block 15 stays put so
    // the index holds 15 through DONE and IDLE.
    assign w_blk_step = ((r_state == S_PREV) && r_flag) || (r_state == S_REM);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_blk <= '0;
        end else if (w_idle && i_mb_start) begin
            r_blk <= '0;
        end else if (w_blk_step && (r_blk != LAST_BLK)) begin
            r_blk <= r_blk + 4'd1;
        end
    end

    // Syntax-element capture; only a completed transfer updates the registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_flag <= 1'b0;
            r_rem  <= '0;
        end else if (w_xfer) begin
            if (r_state == S_WFLAG) r_flag <= i_se_flag;
            if (r_state == S_WREM)  r_rem  <= i_se_rem;
        end
    end

    // Control pulses outside IDLE are dropped and flagged until reset.
    always_ff @(posedge i_clk) begin
        if (i_reset)                                      r_proto_err <= 1'b0;
        else if (!w_idle && (i_mb_start || i_mb_advance)) r_proto_err <= 1'b1;
    end

    mb_position_counter #(.MBW(MBW)) u_pos (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_pic_start (i_pic_start),
        .i_advance   (i_mb_advance && w_idle),
        .i_width_m1  (i_pic_width_in_mbs_minus1),
        .i_height_m1 (i_pic_height_in_map_units_minus1),
        .o_h         (o_mb_num_h),
        .o_v         (o_mb_num_v),
        .o_pic_done  (o_pic_done)
    );

    assign o_luma4x4BlkIdx                = r_blk;
    assign o_prev_intra4x4_pred_mode_flag = r_flag;
    assign o_rem_intra4x4_pred_mode       = r_rem;
    assign o_proto_err                    = r_proto_err;

endmodule
